bank_op_sequencer: RTL
======================

Name: bank_op_sequencer

Overview:
- Command-level controller for one 4-row CELLA bank row decoder.
- Accepts write, MAC and CAM-search commands over a valid/ready handshake.
- Generates the decoder controls as registered, glitch-free signals: cs, clk_copy, w_en, mac_en, read_bar, addr, data, data_bar.
- Sequences multi-row MAC operations one row per clk_copy pulse and reports completion to the bank-level scheduler.

Parameters:
SETUP_CYCLES, 1, cycles with cs/mode/addr/data stable and clk_copy low before each pulse (>=1)
PULSE_CYCLES, 1, cycles clk_copy held high per row access (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE and rst low; transfer when cmd_valid & cmd_ready
cmd_op  input  2  00 write, 01 MAC, 10 CAM search, 11 reserved
cmd_addr  input  2  write row
cmd_row_mask  input  4  MAC rows to access, bit i = row i
cmd_sign  input  4  MAC polarity per row; bit i = 1 drives read_bar=1 for row i
cmd_key  input  4  CAM search key
cmd_care  input  4  CAM care mask (used only with CAM_MASK_EN)
cs  output  1  bank select
clk_copy  output  1  registered access pulse
w_en  output  1  write mode
mac_en  output  1  MAC mode
read_bar  output  1  MAC polarity for current row
addr  output  2  current row
data  output  4  CAM key to decoder
data_bar  output  4  CAM complement key to decoder
row_strobe  output  1  one-cycle sense-sample point, last PULSE cycle of each row/CAM access
row_idx  output  2  row for row_strobe (0 for CAM/write)
done  output  1  one-cycle completion pulse
done_err  output  1  with done: reserved opcode

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0, including data and data_bar. Latched command cleared.
- Reset mid-operation: clk_copy and cs drop asynchronously. No done is produced. The command is discarded.
- All decoder outputs come from flops. Mode, addr, data and read_bar change only in cycles where clk_copy is low.
- FSM states: IDLE, SETUP, PULSE, RECOVER, DONE.
- IDLE:
  - cs=0, clk_copy=0, cmd_ready=1.
  - On handshake, latch op/addr/mask/sign/key/care.
  - Write or CAM -> SETUP.
  - MAC with non-zero mask -> SETUP, with row = lowest set mask bit.
  - MAC with mask 0 -> DONE (no pulse).
  - op 11 -> DONE with done_err.
- SETUP:
  - cs=1, clk_copy=0.
  - Write: w_en=1, addr=cmd_addr.
  - MAC: mac_en=1, addr=current row, read_bar=sign[row].
  - CAM: w_en=0, mac_en=0, data=key, data_bar=~key.
  - Held SETUP_CYCLES cycles -> PULSE.
- PULSE:
  - clk_copy=1 for PULSE_CYCLES cycles. Other outputs unchanged.
  - row_strobe=1 in the final PULSE cycle for MAC and CAM (not write).
  - -> RECOVER.
- RECOVER:
  - One cycle, clk_copy=0, cs=1.
  - MAC with remaining set mask bits above the current row: row = next set bit (ascending) -> SETUP.
  - Otherwise -> DONE.
- DONE:
  - One cycle, done=1. cs, clk_copy, w_en, mac_en, read_bar, data, data_bar, addr all 0.
  - -> IDLE; cmd_ready returns the following cycle.
- Latency, defaults (accept edge = cycle 0):
  - Write/CAM: SETUP c1, PULSE c2, RECOVER c3, done c4.
  - MAC with k rows: done at cycle 1 + 3k.
  - General: each row costs SETUP_CYCLES + PULSE_CYCLES + 1.
- Boundaries:
  - cmd_valid held during busy: ignored, no second accept.
  - Commands are never accepted in the DONE cycle.
  - Mask 4'b1111 visits rows 0,1,2,3 in order.
  - Counters are sized ceil(log2(param+1)) and saturate-free; parameter value 0 is illegal.

Optional Feature:
- Macro CAM_MASK_EN.
  - Defined: during CAM, data = key & care and data_bar = ~key & care. Masked bits drive both lines low (don't-care).
  - Undefined: cmd_care is ignored; data_bar = ~key for all bits.

Test Plan:
- Write, addr=2, defaults: accept c0 -> c1-c3 cs=1, w_en=1, addr=2; clk_copy=1 only c2; done=1 c4; no row_strobe.
- MAC, mask=1010, sign=1000, defaults:
  - Row 1 pulse at c2 with read_bar=0; row 3 pulse at c5 with read_bar=1.
  - row_strobe with row_idx=1 at c2 and row_idx=3 at c5; done c7.
- CAM key=0110, care=0011:
  - With CAM_MASK_EN: data=0010, data_bar=0001 during SETUP/PULSE.
  - Without it: data=0110, data_bar=1001.
  - done c4.
- MAC mask=0000 -> done at c1, clk_copy never high. op=11 -> done=1, done_err=1 at c1.
- rst asserted during PULSE of a MAC -> clk_copy and cs 0 same cycle, no done; after release cmd_ready=1 and a fresh write completes normally.
- SETUP_CYCLES=2, PULSE_CYCLES=3 write -> clk_copy high c3-c5, done c7.

Source files
------------

// File: rtl/bank_op_sequencer.sv
// Command sequencer for one 4-row CELLA bank row decoder.
// Accepts write / MAC / CAM-search commands and emits registered decoder controls.
// Optional build macro: CAM_MASK_EN (CAM care mask applied to data/data_bar).
module bank_op_sequencer #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned PULSE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_addr,
    input  logic [3:0] cmd_row_mask,
    input  logic [3:0] cmd_sign,
    input  logic [3:0] cmd_key,
    input  logic [3:0] cmd_care,
    output logic       cs,
    output logic       clk_copy,
    output logic       w_en,
    output logic       mac_en,
    output logic       read_bar,
    output logic [1:0] addr,
    output logic [3:0] data,
    output logic [3:0] data_bar,
    output logic       row_strobe,
    output logic [1:0] row_idx,
    output logic       done,
    output logic       done_err
);

    localparam int unsigned SW = $clog2(SETUP_CYCLES + 1);
    localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_MAC = 2'b01;
    localparam logic [1:0] OP_CAM = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, RECOVER, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [1:0]    wr_addr_q, wr_addr_d;
    logic [3:0]    mask_q, mask_d;
    logic [3:0]    sign_q, sign_d;
    logic [3:0]    key_q, key_d;
    logic [1:0]    row_q, row_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [3:0]    mask_above;

`ifdef CAM_MASK_EN
    logic [3:0]    care_q, care_d;
`else
    logic          unused_care;
    assign unused_care = ^cmd_care;
`endif

    // Next-cycle output values, registered below
    logic       ready_n, cs_n, clk_copy_n, w_en_n, mac_en_n, read_bar_n;
    logic [1:0] addr_n, row_idx_n;
    logic [3:0] data_n, data_bar_n;
    logic       row_strobe_n, done_n, done_err_n;

    // Index of the lowest set bit (caller guarantees a non-zero mask)
    function automatic logic [1:0] first_set(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // MAC rows strictly above the current row
    assign mask_above = mask_q & (4'b1110 << row_q);

    // State, latched command and phase counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            wr_addr_q <= '0;
            mask_q    <= '0;
            sign_q    <= '0;
            key_q     <= '0;
            row_q     <= '0;
            scnt_q    <= '0;
            pcnt_q    <= '0;
`ifdef CAM_MASK_EN
            care_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wr_addr_q <= wr_addr_d;
            mask_q    <= mask_d;
            sign_q    <= sign_d;
            key_q     <= key_d;
            row_q     <= row_d;
            scnt_q    <= scnt_d;
            pcnt_q    <= pcnt_d;
`ifdef CAM_MASK_EN
            care_q    <= care_d;
`endif
        end
    end

    // Next-state, command latch, row walk and counter update
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wr_addr_d = wr_addr_q;
        mask_d    = mask_q;
        sign_d    = sign_q;
        key_d     = key_q;
        row_d     = row_q;
        scnt_d    = scnt_q;
        pcnt_d    = pcnt_q;
`ifdef CAM_MASK_EN
        care_d    = care_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d      = cmd_op;
                    wr_addr_d = cmd_addr;
                    mask_d    = cmd_row_mask;
                    sign_d    = cmd_sign;
                    key_d     = cmd_key;
`ifdef CAM_MASK_EN
                    care_d    = cmd_care;
`endif
                    row_d     = 2'd0;
                    scnt_d    = '0;
                    pcnt_d    = '0;
                    case (cmd_op)
                        OP_WR, OP_CAM: state_d = SETUP;
                        OP_MAC: begin
                            if (|cmd_row_mask) begin
                                state_d = SETUP;
                                row_d   = first_set(cmd_row_mask);
                            end else begin
                                state_d = DONE;
                            end
                        end
                        default: state_d = DONE;
                    endcase
                end
            end
            SETUP: begin
                if (scnt_q == SW'(SETUP_CYCLES - 1)) begin
                    state_d = PULSE;
                    scnt_d  = '0;
                    pcnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            PULSE: begin
                if (pcnt_q == PW'(PULSE_CYCLES - 1)) begin
                    state_d = RECOVER;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            RECOVER: begin
                if (op_q == OP_MAC && |mask_above) begin
                    state_d = SETUP;
                    row_d   = first_set(mask_above);
                    scnt_d  = '0;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decoder controls for the upcoming state, so every output comes straight from a flop
    always_comb begin
        ready_n      = (state_d == IDLE);
        cs_n         = 1'b0;
        clk_copy_n   = (state_d == PULSE);
        w_en_n       = 1'b0;
        mac_en_n     = 1'b0;
        read_bar_n   = 1'b0;
        addr_n       = 2'd0;
        data_n       = 4'd0;
        data_bar_n   = 4'd0;
        row_strobe_n = 1'b0;
        row_idx_n    = 2'd0;
        done_n       = (state_d == DONE);
        done_err_n   = (state_d == DONE) && (op_d == OP_RSV);
        if (state_d == SETUP || state_d == PULSE || state_d == RECOVER) begin
            cs_n = 1'b1;
            case (op_d)
                OP_WR: begin
                    w_en_n = 1'b1;
                    addr_n = wr_addr_d;
                end
                OP_MAC: begin
                    mac_en_n   = 1'b1;
                    addr_n     = row_d;
                    read_bar_n = sign_d[row_d];
                end
                OP_CAM: begin
`ifdef CAM_MASK_EN
                    data_n     = key_d & care_d;
                    data_bar_n = ~key_d & care_d;
`else
                    data_n     = key_d;
                    data_bar_n = ~key_d;
`endif
                end
                default: ;
            endcase
        end
        if (state_d == PULSE && pcnt_d == PW'(PULSE_CYCLES - 1) &&
            (op_d == OP_MAC || op_d == OP_CAM)) begin
            row_strobe_n = 1'b1;
            row_idx_n    = (op_d == OP_MAC) ? row_d : 2'd0;
        end
    end

    // Output register; async reset drops cs/clk_copy immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready  <= 1'b0;
            cs         <= 1'b0;
            clk_copy   <= 1'b0;
            w_en       <= 1'b0;
            mac_en     <= 1'b0;
            read_bar   <= 1'b0;
            addr       <= '0;
            data       <= '0;
            data_bar   <= '0;
            row_strobe <= 1'b0;
            row_idx    <= '0;
            done       <= 1'b0;
            done_err   <= 1'b0;
        end else begin
            cmd_ready  <= ready_n;
            cs         <= cs_n;
            clk_copy   <= clk_copy_n;
            w_en       <= w_en_n;
            mac_en     <= mac_en_n;
            read_bar   <= read_bar_n;
            addr       <= addr_n;
            data       <= data_n;
            data_bar   <= data_bar_n;
            row_strobe <= row_strobe_n;
            row_idx    <= row_idx_n;
            done       <= done_n;
            done_err   <= done_err_n;
        end
    end

endmodule
